// File: rtl/rr_mux_nx1_pkg.sv
// Shared constants, output-register state type and width helper for rr_mux_nx1.
package rr_mux_nx1_pkg;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_mux_nx1_arbiter.sv
// Request arbiter: round-robin from a rotating pointer, or fixed lowest-index priority.
module rr_arbiter
  import rr_mux_nx1_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned MODE   = MODE_RR,
  localparam int unsigned SELW  = clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_advance,
  output logic [NUM_CH-1:0] o_grant,
  output logic [SELW-1:0]   o_idx,
  output logic              o_any
);

  logic [SELW-1:0] r_ptr;
  logic [SELW:0]   w_sum;
  logic [SELW-1:0] w_cand;
  logic            w_found;

  // Scan channels starting at the pointer, wrapping at NUM_CH; first requester wins.
  // The pointer sits at 0 in fixed mode, so the same scan yields lowest-index priority.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_sum = {1'b0, r_ptr} + (SELW+1)'(i);
      if (w_sum >= (SELW+1)'(NUM_CH)) w_sum = w_sum - (SELW+1)'(NUM_CH);
      w_cand = w_sum[SELW-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_idx            = w_cand;
      end
    end
    o_any = w_found;
  end

  // Pointer moves past the winner only when a transfer really happens.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (MODE == MODE_RR && i_advance && w_found) begin
      r_ptr <= (o_idx == SELW'(NUM_CH - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux_nx1.sv
// N-to-1 data multiplexer with internal arbitration and a one-beat registered output.
module rr_mux_nx1
  import rr_mux_nx1_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned MODE      = MODE_RR,
  localparam int unsigned SELW     = clog2(NUM_CH)
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_CH*DATAWIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]           in_valid,
  output logic [NUM_CH-1:0]           in_ready,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic [SELW-1:0]             out_sel,
  output logic                        out_valid,
  input  logic                        out_ready
);

  out_state_e           r_state;
  logic [DATAWIDTH-1:0] r_data;
  logic [SELW-1:0]      r_sel;

  logic                 w_load;
  logic [NUM_CH-1:0]    w_grant;
  logic [SELW-1:0]      w_idx;
  logic                 w_any;
  logic [DATAWIDTH-1:0] w_sel_data;

  // Output slot can take a beat when empty or being drained; held off while in reset
  // so no producer sees a ready during reset.
  assign w_load = Rst && ((r_state == ST_EMPTY) || out_ready);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE)
  ) u_arb (
    .i_clk     (Clk),
    .i_rst_n   (Rst),
    .i_req     (in_valid),
    .i_advance (w_load),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  assign in_ready  = w_load ? (w_grant & in_valid) : '0;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = (r_state == ST_FULL);

  // Select the granted channel's word.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (w_idx == SELW'(k)) w_sel_data = in_data[k*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Output register: capture on transfer, drain to empty when consumed with nothing new.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_state <= ST_FULL;
        r_data  <= w_sel_data;
        r_sel   <= w_idx;
      end else begin
        r_state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Self-checking bench: round-robin and fixed-priority instances on shared stimulus,
// checked every cycle against a queue-free behavioural model plus literal expectations.
module tb_rr_mux_nx1;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          Clk;
  logic          Rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic          out_ready;

  logic [N-1:0]  rr_in_ready, fx_in_ready;
  logic [DW-1:0] rr_out_data, fx_out_data;
  logic [1:0]    rr_out_sel, fx_out_sel;
  logic          rr_out_valid, fx_out_valid;

  int n_cmp = 0;
  int n_err = 0;

  // model state per instance: 0 = round-robin, 1 = fixed
  bit            mv[2];
  logic [DW-1:0] md[2];
  int            ms[2];
  int            mptr[2];

  rr_mux_nx1 #(.DATAWIDTH(DW), .NUM_CH(N), .MODE(0)) u_rr (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
    .out_valid(rr_out_valid), .out_ready(out_ready)
  );

  rr_mux_nx1 #(.DATAWIDTH(DW), .NUM_CH(N), .MODE(1)) u_fx (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fx_in_ready), .out_data(fx_out_data), .out_sel(fx_out_sel),
    .out_valid(fx_out_valid), .out_ready(out_ready)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner = valid channel with the smallest forward distance from ptr (RR),
  // or the smallest index (fixed). -1 when nothing is valid.
  function automatic int pick(input logic [N-1:0] v, input int ptr, input int mode);
    int best, bestd, d;
    best = -1;
    bestd = N;
    for (int k = 0; k < N; k++) begin
      if (v[k]) begin
        d = (mode == 1) ? k : (k - ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int m);
    int p;
    if (!Rst) return '0;
    if (mv[m] && !out_ready) return '0;
    p = pick(in_valid, mptr[m], m);
    if (p < 0) return '0;
    return N'(1) << p;
  endfunction

  // Behavioural model update
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int m = 0; m < 2; m++) begin
        mv[m] = 1'b0; md[m] = '0; ms[m] = 0; mptr[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int p;
        if (!mv[m] || out_ready) begin
          p = pick(in_valid, mptr[m], m);
          if (p >= 0) begin
            mv[m] = 1'b1;
            md[m] = in_data[p*DW +: DW];
            ms[m] = p;
            if (m == 0) mptr[m] = (p + 1) % N;
          end else begin
            mv[m] = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge Clk) begin
    chk("rr_valid", 32'(rr_out_valid), 32'(mv[0]));
    chk("rr_data",  32'(rr_out_data),  32'(md[0]));
    chk("rr_sel",   32'(rr_out_sel),   32'(ms[0]));
    chk("rr_ready", 32'(rr_in_ready),  32'(exp_ready(0)));
    chk("fx_valid", 32'(fx_out_valid), 32'(mv[1]));
    chk("fx_data",  32'(fx_out_data),  32'(md[1]));
    chk("fx_sel",   32'(fx_out_sel),   32'(ms[1]));
    chk("fx_ready", 32'(fx_in_ready),  32'(exp_ready(1)));
  end

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic rnd_data();
    in_data = {$urandom, $urandom};
  endtask

  task automatic rst_pulse();
    Rst = 1'b0;
    #1;
    chk("rst_rr_valid", 32'(rr_out_valid), 32'd0);
    chk("rst_fx_valid", 32'(fx_out_valid), 32'd0);
    chk("rst_rr_ready", 32'(rr_in_ready), 32'd0);
    #1;
    Rst = 1'b1;
  endtask

  logic [DW-1:0] d0, d1;

  initial begin
    Rst = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    rnd_data();
    #12;
    chk("init_rr_valid", 32'(rr_out_valid), 32'd0);
    chk("init_rr_ready", 32'(rr_in_ready), 32'd0);
    chk("init_rr_data",  32'(rr_out_data), 32'd0);
    chk("init_fx_ready", 32'(fx_in_ready), 32'd0);

    // single beat on channel 2
    Rst = 1'b1;
    in_valid = 4'b0100;
    in_data[2*DW +: DW] = 16'hBEEF;
    cyc();
    chk("single_valid", 32'(rr_out_valid), 32'd1);
    chk("single_data",  32'(rr_out_data), 32'hBEEF);
    chk("single_sel",   32'(rr_out_sel), 32'd2);
    chk("single_fx_sel", 32'(fx_out_sel), 32'd2);

    // round-robin fairness from a fresh pointer
    rst_pulse();
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rnd_data();
      cyc();
      chk("rr_fair_sel", 32'(rr_out_sel), 32'(i % 4));
      chk("fx_fair_sel", 32'(fx_out_sel), 32'd0);
    end

    // fixed priority starves channel 3; RR alternates 1,3
    in_valid = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      rnd_data();
      cyc();
      chk("fx_starve_sel", 32'(fx_out_sel), 32'd1);
      chk("rr_alt_sel", 32'(rr_out_sel), (i % 2 == 1) ? 32'd3 : 32'd1);
    end

    // backpressure
    rst_pulse();
    in_valid = 4'b0001;
    in_data[0 +: DW] = 16'h1234;
    cyc();
    chk("bp_load_data", 32'(rr_out_data), 32'h1234);
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rnd_data();
      cyc();
      chk("bp_hold_data", 32'(rr_out_data), 32'h1234);
      chk("bp_hold_sel",  32'(rr_out_sel), 32'd0);
      chk("bp_hold_valid", 32'(rr_out_valid), 32'd1);
      chk("bp_hold_ready", 32'(rr_in_ready), 32'd0);
      chk("bp_hold_fx_data", 32'(fx_out_data), 32'h1234);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rr_ready", 32'(rr_in_ready), 32'b0010);
    chk("bp_rel_fx_ready", 32'(fx_in_ready), 32'b0001);
    d0 = in_data[0 +: DW];
    d1 = in_data[DW +: DW];
    cyc();
    chk("bp_rel_rr_data", 32'(rr_out_data), 32'(d1));
    chk("bp_rel_rr_sel",  32'(rr_out_sel), 32'd1);
    chk("bp_rel_fx_data", 32'(fx_out_data), 32'(d0));

    // async reset mid-stream
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      rnd_data();
      cyc();
    end
    Rst = 1'b0;
    #1;
    chk("mid_rst_rr_valid", 32'(rr_out_valid), 32'd0);
    chk("mid_rst_fx_valid", 32'(fx_out_valid), 32'd0);
    chk("mid_rst_rr_ready", 32'(rr_in_ready), 32'd0);
    cyc();
    Rst = 1'b1;
    cyc();
    chk("post_rst_valid", 32'(rr_out_valid), 32'd1);
    chk("post_rst_sel",   32'(rr_out_sel), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rnd_data();
      in_valid  = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) rst_pulse();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
